// File: rtl/sb_pkg.sv
// Shared types and helpers for the posted-write store buffer.
package sb_pkg;

  localparam int unsigned STRB_W = 4;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  // One queued store: full address, lane-aligned data and byte enables.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
  } sb_entry_t;

  localparam int unsigned ENTRY_W = $bits(sb_entry_t);

  // Replace the strobed byte lanes of old_word with those of new_word.
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_word,
                                                    input logic [DATA_W-1:0] new_word,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/store_buffer_fifo.sv
// Circular entry storage with head/tail pointers, occupancy and a per-entry
// valid mask so the parent can compare every pending entry in parallel.
module store_buffer_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [W-1:0]              push_data,
  input  logic                      pop,
  output logic [W-1:0]              head_data,
  output logic [DEPTH-1:0][W-1:0]   entries,
  output logic [DEPTH-1:0]          valid,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty,
  output logic                      full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [CNT_W-1:0] count_q;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [W-1:0]     mem_q [DEPTH];

  // Next valid mask: retire the head on pop, claim the tail slot on push.
  always_comb begin
    valid_d = valid_q;
    if (pop)  valid_d[head_q] = 1'b0;
    if (push) valid_d[tail_q] = 1'b1;
  end

  // Pointer, occupancy and valid-mask state; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
      if (push) tail_q <= PTR_W'(tail_q + 1'b1);
      if (pop)  head_q <= PTR_W'(head_q + 1'b1);
      case ({push, pop})
        2'b10:   count_q <= CNT_W'(count_q + 1'b1);
        2'b01:   count_q <= CNT_W'(count_q - 1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payloads; contents are meaningless unless the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= push_data;
  end

  // Expose every slot for the parallel address compare.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) entries[i] = mem_q[i];
  end

  assign head_data = mem_q[head_q];
  assign valid     = valid_q;
  assign count     = count_q;
  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer in front of data_memory: queues strobed stores, drains
// one entry per cycle with a same-cycle read-modify-write, and shares the
// single memory port with core loads (loads hitting a pending store stall).
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   st_valid,
  output logic                   st_ready,
  input  logic [31:0]            st_addr,
  input  logic [31:0]            st_data,
  input  logic [3:0]             st_strb,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [31:0]            ld_addr,
  output logic [31:0]            ld_data,
  output logic [31:0]            mem_a,
  output logic [31:0]            mem_wd,
  output logic                   mem_we,
  input  logic [31:0]            mem_rd,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  sb_entry_t                       push_entry;
  sb_entry_t                       head_entry;
  logic [ENTRY_W-1:0]              head_raw;
  logic [DEPTH-1:0][ENTRY_W-1:0]   entries;
  logic [DEPTH-1:0]                valid;
  logic [DEPTH-1:0]                match;
  logic                            push;
  logic                            drain;
  logic                            ld_hit;
  logic                            unused_entry_bits;

  assign push_entry = '{addr: st_addr, data: st_data, strb: st_strb};
  assign head_entry = head_raw;

  // A store arriving while full waits, even if a drain frees a slot this cycle.
  assign st_ready = !full;
  assign push     = st_valid && !full;

  store_buffer_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (drain),
    .head_data (head_raw),
    .entries   (entries),
    .valid     (valid),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  // Only the address fields take part in the compare; strobes are deliberately ignored.
  always_comb begin
    sb_entry_t e;
    for (int i = 0; i < int'(DEPTH); i++) begin
      e        = entries[i];
      match[i] = valid[i] && (e.addr[ADDR_BITS-1:0] == ld_addr[ADDR_BITS-1:0]);
    end
  end

  assign unused_entry_bits = ^entries;

  // Drain when there is no load, when the load must wait for a matching entry,
  // or when full; the load is otherwise served first, so a hit always drains.
  assign ld_hit   = ld_valid && (|match);
  assign drain    = !empty && (!ld_valid || ld_hit || full);
  assign ld_ready = ld_valid && !drain;

  // Memory port address/enable; kept apart from the mem_rd consumers to avoid a false loop.
  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    if (drain) begin
      mem_a  = head_entry.addr;
      mem_we = 1'b1;
    end else if (ld_ready) begin
      mem_a  = ld_addr;
    end
  end

  // Read-modify-write data for the drain and the zero-latency load return.
  always_comb begin
    mem_wd  = '0;
    ld_data = '0;
    if (drain) begin
      mem_wd = merge_bytes(mem_rd, head_entry.data, head_entry.strb);
    end else if (ld_ready) begin
      ld_data = mem_rd;
    end
  end

endmodule
